pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
- Initiator for the EG_PHY_PLL dynamic phase-shift port (psclksel, psdown, psstep). The PLL is the responder.
- Accepts phase-move commands from the system side, e.g. a PicoRV32 Wishbone CSR bridge. Each command is "channel, direction, N steps".
- Sequences the psstep pulses with setup and settle timing.
- Tracks the signed phase position of each output channel, so software can sweep SDRAM or peripheral clock phase at run time.

Parameters:
- NUM_CH, 5: PLL output channels addressable (psclksel range 0..NUM_CH-1).
- STEP_W, 8: width of the step-count field in a command.
- STEP_HIGH, 2: cycles psstep is held high per step (minimum 1).
- SETTLE_CYCLES, 16: idle cycles after each psstep falls before the next step or done (minimum 1).
- POS_W, 10: width of the per-channel signed phase position counter.

Ports:
- clk, in, 1: system clock; also wired to PLL psclk at top level.
- rst, in, 1: asynchronous active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_sel, in, 3: target channel.
- cmd_down, in, 1: 1 = retard phase, 0 = advance phase.
- cmd_steps, in, STEP_W: number of steps; 0 is legal.
- busy, out, 1: high from the cycle after acceptance until done.
- done, out, 1: one-cycle pulse when a command completes.
- err, out, 1: one-cycle pulse in place of done when cmd_sel >= NUM_CH.
- ps_sel, out, 3: to PLL psclksel.
- ps_down, out, 1: to PLL psdown.
- ps_step, out, 1: to PLL psstep.
- phase_pos, out, NUM_CH*POS_W: packed signed positions, channel 0 in the LSBs (see Optional Feature).

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, err=0, ps_sel=0, ps_down=0, ps_step=0, all positions 0, state=IDLE.
- Reset mid-command aborts at once. ps_step drops asynchronously. A partial step is not counted.
- All outputs are registered.
- States:
  - IDLE: cmd_ready=1. On accept, latch sel, down and steps.
    - If sel >= NUM_CH: go to ERR.
    - Else if steps==0: go to FIN.
    - Else: go to SETUP.
  - SETUP: 1 cycle. ps_sel and ps_down are driven from the latched command and held stable through the whole command. Go to STEP.
  - STEP: ps_step=1 for STEP_HIGH cycles. On exit, remaining is decremented and pos[sel] is updated by -1 if down, +1 otherwise, mod 2^POS_W (wraps, no saturation). Go to SETTLE.
  - SETTLE: ps_step=0 for SETTLE_CYCLES cycles.
    - If remaining != 0: go to STEP; ps_sel and ps_down are not re-set up.
    - If remaining == 0: go to FIN.
  - FIN: done=1 for 1 cycle, then IDLE.
  - ERR: err=1 for 1 cycle, then IDLE. No ps_step activity and no position change.
- Latency for an N>=1 command: accept, then 1 (SETUP) + N*(STEP_HIGH+SETTLE_CYCLES) + 1 (FIN) cycles until done. Done is then followed by one cycle in IDLE.
- cmd_valid while busy is ignored, not queued. The command inputs are only sampled on accept.
- Back-to-back commands: cmd_ready re-asserts the cycle after done or err, so the minimum gap is 1 cycle.
- ps_sel and ps_down never change while ps_step=1.

Optional Feature:
- Macro: PLL_PHASE_POS_TRACK_EN.
- Defined: per-channel POS_W counters are implemented and driven on phase_pos as specified.
- Undefined: no counters are built and phase_pos is tied to 0. Sequencing, done, err and timing are identical.

Decomposition:
- Package pll_phase_pkg holds:
  - state enum (IDLE, SETUP, STEP, SETTLE, FIN, ERR);
  - localparam CNT_W = clog2(max(STEP_HIGH, SETTLE_CYCLES)+1);
  - the channel-index constant for the default 5-channel EG PLL.
- One sub-module, pll_phase_timer: a loadable down-counter with a zero flag. It is reused for both the STEP_HIGH and SETTLE phases.
- Everything else lives in pll_phase_ctrl.

Test Plan:
1. Reset, then cmd sel=1, down=0, steps=3 (defaults) -> exactly 3 ps_step pulses, each 2 cycles high and 16 apart. ps_sel=1 and ps_down=0 are stable throughout. done arrives 1+3*18+1 = 56 cycles after accept. pos[1]=+3.
2. cmd sel=1, down=1, steps=5 after test 1 -> 5 pulses with ps_down=1. pos[1]=-2 (10'h3FE).
3. steps=0 on sel=2 -> no ps_step. done 1 cycle after accept. pos unchanged.
4. sel=6 -> err pulse 1 cycle after accept. No done, no ps_step, positions unchanged.
5. Assert rst during the 2nd STEP of a 4-step command -> ps_step drops immediately. All positions return to 0 and cmd_ready=1. A new command then runs normally.
6. POS_W=4, 17 up-steps on sel=0 -> pos[0] wraps to 1. Build without PLL_PHASE_POS_TRACK_EN -> phase_pos=0 and identical pulse timing.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// Shared definitions for the EG_PHY_PLL dynamic phase-shift controller:
// sequencer state encoding, default timing constants and the timer width helper.
package pll_phase_pkg;

    // Sequencer states for one phase-move command
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        SETTLE,
        FIN,
        ERR
    } state_t;

    // Number of output channels on the EG PLL (psclksel 0..4)
    localparam int EG_PLL_NUM_CH = 5;

    // Default psstep high time and post-step settle time, in clk cycles
    localparam int DEF_STEP_HIGH     = 2;
    localparam int DEF_SETTLE_CYCLES = 16;

    // Width needed to hold the larger of the two phase durations
    function automatic int cnt_width(input int step_high, input int settle_cycles);
        int m;
        m = (step_high > settle_cycles) ? step_high : settle_cycles;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_STEP_HIGH, DEF_SETTLE_CYCLES);

endpackage

// File: rtl/pll_phase_timer.sv
// Loadable down-counter with a zero flag. The controller loads it with
// (duration - 1) on entry to a timed phase and leaves the phase once zero is seen.
import pll_phase_pkg::*;

module pll_phase_timer #(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Phase-shift initiator for the EG_PHY_PLL psclksel/psdown/psstep port.
// Runs "channel, direction, N steps" commands with setup and settle timing,
// and optionally tracks the signed phase position of each channel.
// Optional feature macro: PLL_PHASE_POS_TRACK_EN (per-channel position counters;
// when undefined phase_pos is tied to zero and sequencing is unchanged).
import pll_phase_pkg::*;

module pll_phase_ctrl #(
    parameter int NUM_CH        = EG_PLL_NUM_CH,
    parameter int STEP_W        = 8,
    parameter int STEP_HIGH     = DEF_STEP_HIGH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int POS_W         = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_sel,
    input  logic                    cmd_down,
    input  logic [STEP_W-1:0]       cmd_steps,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              ps_sel,
    output logic                    ps_down,
    output logic                    ps_step,
    output logic [NUM_CH*POS_W-1:0] phase_pos
);

    localparam int TMR_W = cnt_width(STEP_HIGH, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] STEP_LOAD   = TMR_W'(STEP_HIGH - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [2:0]          ps_sel_q, ps_sel_d;
    logic                ps_down_q, ps_down_d;
    logic                ps_step_q, ps_step_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;
    logic                pos_step;

    pll_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state logic; every output is derived from the next state so it is registered
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ps_sel_d    = ps_sel_q;
        ps_down_d   = ps_down_q;
        tmr_load    = 1'b0;
        tmr_val     = STEP_LOAD;
        pos_step    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (int'(cmd_sel) >= NUM_CH) begin
                        state_d = ERR;
                    end else if (cmd_steps == '0) begin
                        state_d = FIN;
                    end else begin
                        // Channel and direction are set up once and held for the whole command
                        state_d     = SETUP;
                        ps_sel_d    = cmd_sel;
                        ps_down_d   = cmd_down;
                        remaining_d = cmd_steps;
                    end
                end
            end
            SETUP: begin
                state_d  = STEP;
                tmr_load = 1'b1;
                tmr_val  = STEP_LOAD;
            end
            STEP: begin
                if (tmr_zero) begin
                    // Step is only counted once psstep has been held for its full width
                    state_d     = SETTLE;
                    remaining_d = remaining_q - 1'b1;
                    pos_step    = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    if (remaining_q != '0) begin
                        state_d  = STEP;
                        tmr_load = 1'b1;
                        tmr_val  = STEP_LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        err_d       = (state_d == ERR);
        ps_step_d   = (state_d == STEP);
    end

    // FSM state and registered outputs; reset clears psstep immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            ps_sel_q    <= '0;
            ps_down_q   <= 1'b0;
            ps_step_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ps_sel_q    <= ps_sel_d;
            ps_down_q   <= ps_down_d;
            ps_step_q   <= ps_step_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ps_sel    = ps_sel_q;
    assign ps_down   = ps_down_q;
    assign ps_step   = ps_step_q;

`ifdef PLL_PHASE_POS_TRACK_EN
    logic [POS_W-1:0] pos_q [NUM_CH];
    logic [POS_W-1:0] pos_d [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pos
            // Per-channel position: +1 per advance step, -1 per retard step, wrapping
            always_comb begin
                pos_d[gi] = pos_q[gi];
                if (pos_step && (int'(ps_sel_q) == gi)) begin
                    pos_d[gi] = ps_down_q ? (pos_q[gi] - 1'b1) : (pos_q[gi] + 1'b1);
                end
            end

            // Position register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pos_q[gi] <= '0;
                end else begin
                    pos_q[gi] <= pos_d[gi];
                end
            end

            assign phase_pos[gi*POS_W +: POS_W] = pos_q[gi];
        end
    endgenerate
`else
    logic unused_pos_step;
    assign unused_pos_step = pos_step;
    assign phase_pos       = '0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: each command pushes its expected outcome,
// which is popped and compared when the DUT signals done or err.
module tb_pll_phase_ctrl;

    localparam int NUM_CH = 5;
    localparam int STEP_W = 8;
    localparam int SH     = 2;
    localparam int SC     = 16;
    localparam int POS_W  = 10;
    localparam int WPOS_W = 4;

`ifdef PLL_PHASE_POS_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [2:0]              cmd_sel = '0;
    logic                    cmd_down = 1'b0;
    logic [STEP_W-1:0]       cmd_steps = '0;
    logic                    busy, done, err;
    logic [2:0]              ps_sel;
    logic                    ps_down, ps_step;
    logic [NUM_CH*POS_W-1:0] phase_pos;

    logic                     w_valid = 1'b0;
    logic                     w_ready;
    logic                     w_busy, w_done, w_err;
    logic [2:0]               w_ps_sel;
    logic                     w_ps_down, w_ps_step;
    logic [NUM_CH*WPOS_W-1:0] w_phase_pos;

    always #5 clk = ~clk;

    pll_phase_ctrl #(
        .NUM_CH(NUM_CH), .STEP_W(STEP_W), .STEP_HIGH(SH), .SETTLE_CYCLES(SC), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_down(cmd_down), .cmd_steps(cmd_steps),
        .busy(busy), .done(done), .err(err), .ps_sel(ps_sel), .ps_down(ps_down),
        .ps_step(ps_step), .phase_pos(phase_pos)
    );

    pll_phase_ctrl #(
        .NUM_CH(NUM_CH), .STEP_W(STEP_W), .STEP_HIGH(SH), .SETTLE_CYCLES(SC), .POS_W(WPOS_W)
    ) dut_w (
        .clk(clk), .rst(rst), .cmd_valid(w_valid), .cmd_ready(w_ready),
        .cmd_sel(3'd0), .cmd_down(1'b0), .cmd_steps(8'd17),
        .busy(w_busy), .done(w_done), .err(w_err), .ps_sel(w_ps_sel), .ps_down(w_ps_down),
        .ps_step(w_ps_step), .phase_pos(w_phase_pos)
    );

    typedef struct {
        bit         is_err;
        int         lat;
        int         pulses;
        logic [2:0] sel;
        bit         down;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    logic [POS_W-1:0] pos_m [NUM_CH];

    function automatic logic [NUM_CH*POS_W-1:0] exp_pos();
        logic [NUM_CH*POS_W-1:0] v;
        v = '0;
        if (TRACK) begin
            for (int i = 0; i < NUM_CH; i++) v[i*POS_W +: POS_W] = pos_m[i];
        end
        return v;
    endfunction

    // Issue one command from a negedge with cmd_ready high; returns at the negedge of the
    // idle cycle after completion so the next call runs back to back
    task automatic run_cmd(input logic [2:0] sel, input bit down, input int steps, input bit hold_busy);
        exp_t e;
        exp_t g;
        int   lat, pulses, hi, last_rise;
        bit   fin;
        e.is_err = (int'(sel) >= NUM_CH);
        e.lat    = (e.is_err || steps == 0) ? 1 : 2 + steps * (SH + SC);
        e.pulses = e.is_err ? 0 : steps;
        e.sel    = sel;
        e.down   = down;
        sb.push_back(e);

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_cmd: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_sel = sel; cmd_down = down; cmd_steps = 8'(steps);
        @(posedge clk); #1;
        if (hold_busy) begin
            cmd_sel = 3'd4; cmd_down = ~down; cmd_steps = 8'd7;
        end else begin
            cmd_valid = 1'b0;
        end
        lat = 0; pulses = 0; hi = 0; last_rise = 0; fin = 1'b0;
        while (!fin && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checks++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL busy_after_accept: busy=%b ready=%b expected 1/0", busy, cmd_ready);
                end
            end
            if (ps_step === 1'b1) begin
                if (hi == 0) begin
                    pulses++;
                    if (pulses > 1) begin
                        checks++;
                        if (lat - last_rise != SH + SC) begin
                            errors++; $display("FAIL step_spacing: got %0d expected %0d", lat - last_rise, SH + SC);
                        end
                    end
                    last_rise = lat;
                end
                hi++;
                checks++;
                if (ps_sel !== sel || ps_down !== down) begin
                    errors++; $display("FAIL sel_down_stable: got sel=%0d down=%b expected sel=%0d down=%b", ps_sel, ps_down, sel, down);
                end
            end else if (hi != 0) begin
                checks++;
                if (hi != SH) begin
                    errors++; $display("FAIL step_width: got %0d expected %0d", hi, SH);
                end
                hi = 0;
            end
            if (done === 1'b1 || err === 1'b1) fin = 1'b1;
        end
        if (hold_busy) cmd_valid = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: got no done/err after %0d cycles expected %0d", lat, e.lat);
            void'(sb.pop_front());
        end else begin
            g = sb.pop_front();
            checks++;
            if (lat != g.lat) begin
                errors++; $display("FAIL latency: got %0d expected %0d", lat, g.lat);
            end
            checks++;
            if (err !== g.is_err || done !== !g.is_err) begin
                errors++; $display("FAIL done_err_kind: got done=%b err=%b expected err=%b", done, err, g.is_err);
            end
            checks++;
            if (pulses != g.pulses) begin
                errors++; $display("FAIL pulse_count: got %0d expected %0d", pulses, g.pulses);
            end
        end
        if (!e.is_err) begin
            pos_m[sel] = down ? pos_m[sel] - POS_W'(steps) : pos_m[sel] + POS_W'(steps);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL after_done: done=%b err=%b busy=%b ready=%b expected 0/0/0/1", done, err, busy, cmd_ready);
        end
        checks++;
        if (phase_pos !== exp_pos()) begin
            errors++; $display("FAIL phase_pos: got %h expected %h", phase_pos, exp_pos());
        end
        $display("cmd sel=%0d down=%0d steps=%0d lat=%0d pulses=%0d pos=%h", sel, down, steps, lat, pulses, phase_pos);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            ps_sel !== 3'd0 || ps_down !== 1'b0 || ps_step !== 1'b0 || phase_pos !== '0) begin
            errors++; $display("FAIL reset_values: ready=%b busy=%b done=%b err=%b sel=%0d down=%b step=%b pos=%h expected 1/0/0/0/0/0/0/0",
                               cmd_ready, busy, done, err, ps_sel, ps_down, ps_step, phase_pos);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset released ready=%b", cmd_ready);
    endtask

    task automatic test_advance();   run_cmd(3'd1, 1'b0, 3, 1'b0); endtask
    task automatic test_retard();    run_cmd(3'd1, 1'b1, 5, 1'b0); endtask
    task automatic test_zero_steps(); run_cmd(3'd2, 1'b0, 0, 1'b0); endtask

    task automatic test_bad_sel();
        run_cmd(3'd6, 1'b0, 2, 1'b0);
        run_cmd(3'd5, 1'b1, 1, 1'b0);
    endtask

    // Command inputs toggled while busy must be ignored; next command follows after a 1-cycle gap
    task automatic test_back_to_back();
        run_cmd(3'd4, 1'b1, 2, 1'b1);
        run_cmd(3'd0, 1'b0, 1, 1'b0);
        run_cmd(3'd3, 1'b0, 1, 1'b0);
    endtask

    task automatic test_reset_abort();
        int pulses, lat;
        bit prev;
        logic [NUM_CH*POS_W-1:0] mid;
        cmd_valid = 1'b1; cmd_sel = 3'd2; cmd_down = 1'b0; cmd_steps = 8'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        pulses = 0; lat = 0; prev = 1'b0;
        while (pulses < 2 && lat < 500) begin
            @(negedge clk);
            lat++;
            if (ps_step === 1'b1 && !prev) pulses++;
            prev = (ps_step === 1'b1);
        end
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL abort_second_step: got %0d pulses expected 2", pulses);
        end
        pos_m[2] = pos_m[2] + 1'b1;
        mid = exp_pos();
        checks++;
        if (phase_pos !== mid) begin
            errors++; $display("FAIL abort_mid_pos: got %h expected %h", phase_pos, mid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ps_step !== 1'b0 || phase_pos !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_reset: step=%b pos=%h ready=%b busy=%b done=%b expected 0/0/1/0/0",
                               ps_step, phase_pos, cmd_ready, busy, done);
        end
        for (int i = 0; i < NUM_CH; i++) pos_m[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset abort step=%b pos=%h", ps_step, phase_pos);
        run_cmd(3'd2, 1'b1, 2, 1'b0);
    endtask

    task automatic test_wrap();
        int lat, pulses;
        bit prev, fin;
        logic [NUM_CH*WPOS_W-1:0] wexp;
        w_valid = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b0;
        lat = 0; pulses = 0; prev = 1'b0; fin = 1'b0;
        while (!fin && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (w_ps_step === 1'b1 && !prev) pulses++;
            prev = (w_ps_step === 1'b1);
            if (w_done === 1'b1) fin = 1'b1;
        end
        wexp = '0;
        wexp[WPOS_W-1:0] = TRACK ? 4'd1 : 4'd0;
        checks++;
        if (lat != 2 + 17 * (SH + SC)) begin
            errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, 2 + 17 * (SH + SC));
        end
        checks++;
        if (pulses != 17) begin
            errors++; $display("FAIL wrap_pulses: got %0d expected 17", pulses);
        end
        checks++;
        if (w_phase_pos !== wexp) begin
            errors++; $display("FAIL wrap_pos: got %h expected %h", w_phase_pos, wexp);
        end
        $display("wrap lat=%0d pulses=%0d pos=%h", lat, pulses, w_phase_pos);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) pos_m[i] = '0;
        test_reset();
        test_advance();
        test_retard();
        test_zero_steps();
        test_bad_sel();
        test_back_to_back();
        test_reset_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
